// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the SDRAM controller command port between the CPU data master and
// the VGA frame DMA. Whole bursts are granted; VGA wins arbitration unless the
// CPU has waited STARVE_LIMIT cycles. Outstanding reads are tracked in order so
// each returned beat is routed to the requester that issued it.
//
// Optional build macro: SDRAM_ARB_STATS_EN adds the io_cpuGrants/io_vgaGrants
// grant counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | arbitration cycle, no grant, all cmd_ready low
// CPU_BURST | CPU owns the controller port until its last beat handshakes
// VGA_BURST | VGA owns the controller port until its last beat handshakes

module sdram_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int RSP_DEPTH    = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                io_axiClk,
    input  logic                io_asyncReset,

    input  logic                io_cpu_cmd_valid,
    output logic                io_cpu_cmd_ready,
    input  logic                io_cpu_cmd_write,
    input  logic [ADDR_W-1:0]   io_cpu_cmd_address,
    input  logic [DATA_W-1:0]   io_cpu_cmd_data,
    input  logic [DATA_W/8-1:0] io_cpu_cmd_mask,
    input  logic                io_cpu_cmd_last,
    output logic                io_cpu_rsp_valid,
    output logic [DATA_W-1:0]   io_cpu_rsp_data,

    input  logic                io_vga_cmd_valid,
    output logic                io_vga_cmd_ready,
    input  logic [ADDR_W-1:0]   io_vga_cmd_address,
    input  logic                io_vga_cmd_last,
    output logic                io_vga_rsp_valid,
    output logic [DATA_W-1:0]   io_vga_rsp_data,

    output logic                io_ctrl_cmd_valid,
    input  logic                io_ctrl_cmd_ready,
    output logic                io_ctrl_cmd_write,
    output logic [ADDR_W-1:0]   io_ctrl_cmd_address,
    output logic [DATA_W-1:0]   io_ctrl_cmd_data,
    output logic [DATA_W/8-1:0] io_ctrl_cmd_mask,
    input  logic                io_ctrl_rsp_valid,
    input  logic [DATA_W-1:0]   io_ctrl_rsp_data,

    output logic                io_rspError
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [15:0]         io_cpuGrants,
    output logic [15:0]         io_vgaGrants
`endif
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_BURST = 2'd1,
        VGA_BURST = 2'd2
    } state_t;

    state_t               state;
    logic [STARVE_W-1:0]  starve;
    logic [RSP_DEPTH-1:0] src_mem;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 owner_valid;
    logic                 owner_write;
    logic                 owner_last;
    logic [ADDR_W-1:0]    owner_address;
    logic [DATA_W-1:0]    owner_data;
    logic [MASK_W-1:0]    owner_mask;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 head_src;
    logic                 beat_accept;
    logic                 starve_ok;
    logic                 vga_go;
    logic                 cpu_go;

    assign fifo_full  = (count == CNT_W'(RSP_DEPTH));
    assign fifo_empty = (count == '0);
    assign fifo_pop   = io_ctrl_rsp_valid & ~fifo_empty;
    assign head_src   = src_mem[rd_ptr];

    assign starve_ok  = (starve < STARVE_W'(STARVE_LIMIT));
    assign vga_go     = (state == IDLE) & io_vga_cmd_valid & starve_ok;
    assign cpu_go     = (state == IDLE) & ~vga_go & io_cpu_cmd_valid;

    // Owner mux: the granted master's command passes straight through; IDLE drives zeros.
    always_comb begin
        owner_valid   = 1'b0;
        owner_write   = 1'b0;
        owner_last    = 1'b0;
        owner_address = '0;
        owner_data    = '0;
        owner_mask    = '0;
        case (state)
            CPU_BURST: begin
                owner_valid   = io_cpu_cmd_valid;
                owner_write   = io_cpu_cmd_write;
                owner_last    = io_cpu_cmd_last;
                owner_address = io_cpu_cmd_address;
                owner_data    = io_cpu_cmd_data;
                owner_mask    = io_cpu_cmd_mask;
            end
            VGA_BURST: begin
                owner_valid   = io_vga_cmd_valid;
                owner_last    = io_vga_cmd_last;
                owner_address = io_vga_cmd_address;
            end
            default: ;
        endcase
    end

    // A read may only go out with a free source slot; a same-cycle pop frees one.
    assign io_ctrl_cmd_valid   = owner_valid & (owner_write | ~fifo_full | fifo_pop);
    assign io_ctrl_cmd_write   = owner_write;
    assign io_ctrl_cmd_address = owner_address;
    assign io_ctrl_cmd_data    = owner_data;
    assign io_ctrl_cmd_mask    = owner_mask;

    assign beat_accept      = io_ctrl_cmd_valid & io_ctrl_cmd_ready;
    assign fifo_push        = beat_accept & ~owner_write;
    assign io_cpu_cmd_ready = (state == CPU_BURST) & beat_accept;
    assign io_vga_cmd_ready = (state == VGA_BURST) & beat_accept;

    assign io_cpu_rsp_valid = fifo_pop & ~head_src;
    assign io_vga_rsp_valid = fifo_pop & head_src;
    assign io_cpu_rsp_data  = io_ctrl_rsp_data;
    assign io_vga_rsp_data  = io_ctrl_rsp_data;

    // Burst ownership: grant from IDLE, return to IDLE on the last beat's handshake.
    always_ff @(posedge io_axiClk or negedge io_asyncReset) begin
        if (!io_asyncReset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (vga_go)
                        state <= VGA_BURST;
                    else if (cpu_go)
                        state <= CPU_BURST;
                end
                CPU_BURST, VGA_BURST: begin
                    if (beat_accept && owner_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU wait counter; saturates so the CPU keeps its claim until granted.
    always_ff @(posedge io_axiClk or negedge io_asyncReset) begin
        if (!io_asyncReset) begin
            starve <= '0;
        end else if (cpu_go) begin
            starve <= '0;
        end else if (io_cpu_cmd_valid && (state != CPU_BURST) && starve_ok) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    // In-order source FIFO for outstanding reads (0 = CPU, 1 = VGA).
    always_ff @(posedge io_axiClk or negedge io_asyncReset) begin
        if (!io_asyncReset) begin
            src_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (fifo_push) begin
                src_mem[wr_ptr] <= (state == VGA_BURST);
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Sticky flag for a response beat that no read was waiting for.
    always_ff @(posedge io_axiClk or negedge io_asyncReset) begin
        if (!io_asyncReset)
            io_rspError <= 1'b0;
        else if (io_ctrl_rsp_valid && fifo_empty)
            io_rspError <= 1'b1;
    end

`ifdef SDRAM_ARB_STATS_EN
    // Grant counters, one tick per burst grant, free-running wrap.
    always_ff @(posedge io_axiClk or negedge io_asyncReset) begin
        if (!io_asyncReset) begin
            io_cpuGrants <= 16'd0;
            io_vgaGrants <= 16'd0;
        end else begin
            if (cpu_go)
                io_cpuGrants <= io_cpuGrants + 16'd1;
            if (vga_go)
                io_vgaGrants <= io_vgaGrants + 16'd1;
        end
    end
`endif

endmodule
